// File: rtl/dnn_weight_stream.sv
// dnn_weight_stream: fetches weight blocks from memory and streams them word by word
// into the neuron weight registers of every configured layer, skipping empty layers.
module dnn_weight_stream #(
   parameter int unsigned NUM_LAYERS  = 6,
   parameter int unsigned WORD_W      = 64,
   parameter int unsigned BLOCK_WORDS = 8,
   parameter int unsigned NEURON_W    = 5,
   parameter int unsigned WEIGHT_W    = 7,
   parameter int unsigned ADDR_W      = 32,
   localparam int unsigned LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   input  logic [ADDR_W-1:0]               base_addr,
   input  logic [NEURON_W*NUM_LAYERS-1:0]  cfg_neurons,
   input  logic [WEIGHT_W*NUM_LAYERS-1:0]  cfg_weights,
   output logic                            req_mem,
   output logic [ADDR_W-1:0]               mem_addr,
   input  logic                            mem_ready,
   input  logic [WORD_W*BLOCK_WORDS-1:0]   mem_data,
   output logic [WORD_W-1:0]               weight_bus,
   output logic [LAYER_W-1:0]              layer_sel,
   output logic [NEURON_W-1:0]             neuron_sel,
   output logic [WEIGHT_W-1:0]             weight_sel,
   output logic                            write_weight,
   input  logic                            weight_ready,
   output logic                            weight_valid,
   output logic                            busy
);

   localparam int unsigned WC_W = $clog2(BLOCK_WORDS);
   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
   localparam logic [WC_W-1:0]    LAST_WORD  = WC_W'(BLOCK_WORDS - 1);

   typedef enum logic [2:0] {IDLE, SKIP, REQ, WAIT, LOAD, NEXT} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [WC_W-1:0]     word_cnt;
   logic [WORD_W-1:0]   blk_buf [BLOCK_WORDS];

   logic [NEURON_W-1:0] neurons_arr [NUM_LAYERS];
   logic [WEIGHT_W-1:0] weights_arr [NUM_LAYERS];
   logic [NEURON_W-1:0] cur_neurons;
   logic [WEIGHT_W-1:0] cur_weights;
   logic                layer_empty;
   logic                last_weight;
   logic                more_neurons;
   logic [WC_W-1:0]     word_nxt;

   // Unpack the per-layer configuration vectors.
   for (genvar g = 0; g < int'(NUM_LAYERS); g++) begin : g_cfg
      assign neurons_arr[g] = cfg_neurons[g*NEURON_W +: NEURON_W];
      assign weights_arr[g] = cfg_weights[g*WEIGHT_W +: WEIGHT_W];
   end

   // Current-layer decode used by the sequencer.
   always_comb begin
      cur_neurons  = neurons_arr[layer_sel];
      cur_weights  = weights_arr[layer_sel];
      layer_empty  = (cur_neurons == '0) || (cur_weights == '0);
      last_weight  = (weight_sel == (cur_weights - WEIGHT_W'(1)));
      more_neurons = (neuron_sel < (cur_neurons - NEURON_W'(1)));
      word_nxt     = word_cnt + WC_W'(1);
   end

   // Load sequencer with registered outputs; abort overrides everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         addr_cnt     <= '0;
         word_cnt     <= '0;
         req_mem      <= 1'b0;
         mem_addr     <= '0;
         weight_bus   <= '0;
         layer_sel    <= '0;
         neuron_sel   <= '0;
         weight_sel   <= '0;
         write_weight <= 1'b0;
         weight_valid <= 1'b0;
         busy         <= 1'b0;
         for (int i = 0; i < int'(BLOCK_WORDS); i++) blk_buf[i] <= '0;
      end else begin
         req_mem      <= 1'b0;
         weight_valid <= 1'b0;
         if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            write_weight <= 1'b0;
            addr_cnt     <= '0;
            word_cnt     <= '0;
            mem_addr     <= '0;
            layer_sel    <= '0;
            neuron_sel   <= '0;
            weight_sel   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state      <= SKIP;
                     busy       <= 1'b1;
                     addr_cnt   <= base_addr;
                     word_cnt   <= '0;
                     layer_sel  <= '0;
                     neuron_sel <= '0;
                     weight_sel <= '0;
                  end
               end
               SKIP: begin
                  if (!layer_empty) begin
                     state    <= REQ;
                     req_mem  <= 1'b1;
                     mem_addr <= addr_cnt;
                     addr_cnt <= addr_cnt + ADDR_W'(1);
                  end else if (layer_sel == LAST_LAYER) begin
                     state        <= IDLE;
                     busy         <= 1'b0;
                     weight_valid <= 1'b1;
                  end else begin
                     layer_sel <= layer_sel + LAYER_W'(1);
                  end
               end
               REQ: state <= WAIT;
               WAIT: begin
                  if (mem_ready) begin
                     for (int i = 0; i < int'(BLOCK_WORDS); i++)
                        blk_buf[i] <= mem_data[i*WORD_W +: WORD_W];
                     word_cnt     <= '0;
                     weight_bus   <= mem_data[WORD_W-1:0];
                     write_weight <= 1'b1;
                     state        <= LOAD;
                  end
               end
               LOAD: begin
                  if (weight_ready) begin
                     word_cnt   <= word_nxt;
                     weight_sel <= weight_sel + WEIGHT_W'(1);
                     if (last_weight) begin
                        write_weight <= 1'b0;
                        state        <= NEXT;
                     end else if (word_cnt == LAST_WORD) begin
                        write_weight <= 1'b0;
                        state        <= REQ;
                        req_mem      <= 1'b1;
                        mem_addr     <= addr_cnt;
                        addr_cnt     <= addr_cnt + ADDR_W'(1);
                     end else begin
                        weight_bus <= blk_buf[word_nxt];
                     end
                  end
               end
               NEXT: begin
                  weight_sel <= '0;
                  if (more_neurons) begin
                     neuron_sel <= neuron_sel + NEURON_W'(1);
                     state      <= REQ;
                     req_mem    <= 1'b1;
                     mem_addr   <= addr_cnt;
                     addr_cnt   <= addr_cnt + ADDR_W'(1);
                  end else begin
                     neuron_sel <= '0;
                     if (layer_sel == LAST_LAYER) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        weight_valid <= 1'b1;
                     end else begin
                        layer_sel <= layer_sel + LAYER_W'(1);
                        state     <= SKIP;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/dnn_weight_stream.md
# dnn_weight_stream

Parametrised successor to the fixed A/B/C weight loader: fetches weight blocks from memory and streams them one word at a time into the neuron weight registers of an arbitrary number of layers. Per-layer neuron and weight counts come from configuration inputs instead of hard-coded state chains. The block adds memory addressing, neuron-side backpressure, empty-layer skipping and abort. It sits between the DNN memory interface and the neuron array, and its sequencing is driven by the DNN controller.

## Interface
- NUM_LAYERS, 6, number of layer descriptors (≥1)
- WORD_W, 64, weight bus width
- BLOCK_WORDS, 8, words per memory block (power of 2, ≥2)
- NEURON_W, 5, width of per-layer neuron count
- WEIGHT_W, 7, width of per-neuron weight count
- ADDR_W, 32, memory block address width
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin load; sampled only in IDLE
- abort  in  1  terminate load; has priority over all other inputs
- base_addr  in  ADDR_W  first block address; latched on accepted start
- cfg_neurons  in  NEURON_W×NUM_LAYERS  neurons per layer; 0 = skip layer
- cfg_weights  in  WEIGHT_W×NUM_LAYERS  weights per neuron; 0 = skip layer
- req_mem  out  1  one-cycle block request
- mem_addr  out  ADDR_W  block address; valid while req_mem is high
- mem_ready  in  1  mem_data valid; sampled only in WAIT
- mem_data  in  WORD_W×BLOCK_WORDS  fetched block
- weight_bus  out  WORD_W  current weight word
- layer_sel  out  clog2(NUM_LAYERS)  target layer
- neuron_sel  out  NEURON_W  target neuron within layer
- weight_sel  out  WEIGHT_W  target weight index within neuron
- write_weight  out  1  weight_bus/selects valid
- weight_ready  in  1  neuron array accepts; transfer = write_weight & weight_ready
- weight_valid  out  1  one-cycle pulse: every configured weight has been written
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SKIP, REQ, WAIT, LOAD, NEXT.
- IDLE & start: latch base_addr into the address counter; clear the layer, neuron, weight and word counters; go to SKIP.
- SKIP: if the current layer has cfg_neurons==0 or cfg_weights==0, increment layer_sel (one layer per cycle). When the current layer is non-empty, go to REQ. If no non-empty layer remains, pulse weight_valid and go to IDLE. A load with every layer empty therefore completes with only a weight_valid pulse.
- REQ: assert req_mem with mem_addr; go to WAIT. The address counter increments after each request.
- WAIT: on mem_ready, capture all of mem_data into the block buffer, clear word_cnt and go to LOAD. The memory never responds in the REQ cycle.
- LOAD: drive write_weight=1 and weight_bus=buffer[word_cnt]. Each transfer increments word_cnt and weight_sel. If weight_ready is low, the outputs and counters hold.
  - If the transfer carries the neuron's last weight (weight_sel == cfg_weights−1), go to NEXT. Any unused words left in the block are discarded, so every neuron starts on a fresh block.
  - Else if the transfer carries the last word of the block (word_cnt == BLOCK_WORDS−1), go to REQ.
- NEXT: clear weight_sel.
  - If neuron_sel < cfg_neurons−1: increment neuron_sel and go to REQ.
  - Otherwise: clear neuron_sel, increment layer_sel and go to SKIP. If this was the last layer, pulse weight_valid instead and go to IDLE.
- cfg_* inputs must be held stable while busy. The block samples them live and does not latch them.
- abort, in any state: next state is IDLE, all counters clear, and weight_valid does not pulse. A mem_ready response still outstanding at that point is ignored.
- start while busy is ignored. If abort and start are asserted in the same cycle in IDLE, the block stays in IDLE.
- mem_ready outside WAIT is ignored.
- The address counter wraps modulo 2^ADDR_W.

## Timing
- Reset values: state IDLE, req_mem 0, mem_addr 0, write_weight 0, weight_valid 0, busy 0, all selects 0, weight_bus 0, block buffer 0.
- From start to the first req_mem: 2 cycles (IDLE→SKIP→REQ) when layer 0 is non-empty, plus 1 cycle per skipped layer.
- From mem_ready to the first write_weight: 1 cycle.
- With weight_ready held high, one word transfers per cycle.
- Block refetch within a neuron costs REQ + WAIT (≥2 cycles) between words.
- Neuron boundary costs NEXT + REQ + WAIT.
- weight_valid is asserted in the cycle the state returns to IDLE; busy is 0 in the following cycle.

## Test plan
- NUM_LAYERS=3, cfg_neurons={2,0,1}, cfg_weights={10,5,3}, base_addr=0x100, zero-latency memory, weight_ready=1 -> exactly 5 requests at addresses 0x100..0x104:
  - L0 N0 writes 8 weights then 2, and N1 does the same (4 requests).
  - Layer 1 is skipped.
  - L2 N0 writes 3 weights.
  - Exactly one weight_valid pulse.
- Backpressure: weight_ready toggled 1,0,0,1… -> weight_bus and the selects hold while stalled; no weight is duplicated or dropped; the order of weight_sel values is unchanged.
- Delayed memory (mem_ready 5 cycles after req_mem), with a mem_ready glitch injected during LOAD -> the glitch is ignored, the buffer is not overwritten and the data is correct.
- abort asserted mid-LOAD of layer 0, neuron 1 -> IDLE on the next cycle; no weight_valid; a new start restarts from base_addr with all selects 0.
- All cfg_neurons=0 -> no req_mem; weight_valid pulses NUM_LAYERS+1 cycles after start.
- Async rst asserted mid-WAIT -> all outputs immediately take their reset values; a late mem_ready is ignored.
